hv_assoc_search: RTL and testbench

- Associative-memory search stage on the inference side of the sparse HDC pipeline.
- Consumes the query hypervector one thresholded bit per handshake, in the form the bundler emits it.
- Scores the query against every stored class hypervector by overlap count, popcount(query AND class), and returns the best class.
- Class hypervectors live in an external synchronous RAM, read CHUNK_W bits per cycle.

---
 rtl/hdc_pkg.sv | 16 +
 rtl/hv_assoc_search_if.sv | 24 ++
 rtl/popcount_chunk.sv | 29 ++
 rtl/hv_assoc_search.sv | 114 +++++++++++
 tb/tb_hv_assoc_search.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hdc_pkg.sv
// Shared sizing and state encoding for the HDC associative-search stage.
package hdc_pkg;
    localparam int HV_DIM      = 1024;
    localparam int CHUNK_W     = 64;
    localparam int CLASS_COUNT = 26;

    localparam int NCHUNK   = HV_DIM / CHUNK_W;
    localparam int SCORE_W  = $clog2(HV_DIM + 1);
    localparam int CLASS_W  = $clog2(CLASS_COUNT);
    localparam int ADDR_W   = $clog2(CLASS_COUNT * NCHUNK);
    localparam int BIT_W    = $clog2(HV_DIM);
    localparam int CHUNK_IW = $clog2(NCHUNK);
    localparam int PC_W     = $clog2(CHUNK_W + 1);

    typedef enum logic [2:0] {IDLE, LOAD, SEARCH, DRAIN, DONE} state_t;
endpackage

// File: rtl/hv_assoc_search_if.sv
// Query stream, class-RAM read port and result handshake of the search stage.
interface hv_assoc_search_if;
    import hdc_pkg::*;

    logic               query_valid;
    logic               query_bit;
    logic               query_ready;
    logic               mem_rd_en;
    logic [ADDR_W-1:0]  mem_rd_addr;
    logic [CHUNK_W-1:0] mem_rd_data;
    logic               result_valid;
    logic               result_ready;
    logic [CLASS_W-1:0] result_class;
    logic [SCORE_W-1:0] result_score;

    modport slave (
        input  query_valid, query_bit, mem_rd_data, result_ready,
        output query_ready, mem_rd_en, mem_rd_addr, result_valid, result_class, result_score
    );
    modport master (
        output query_valid, query_bit, mem_rd_data, result_ready,
        input  query_ready, mem_rd_en, mem_rd_addr, result_valid, result_class, result_score
    );
endinterface

// File: rtl/popcount_chunk.sv
// Combinational binary-tree popcount; input is zero-padded to a power of two.
module popcount_chunk #(
    parameter int W  = 64,
    parameter int OW = $clog2(W + 1)
) (
    input  logic [W-1:0]  din,
    output logic [OW-1:0] cnt
);
    localparam int LV = $clog2(W);
    localparam int P  = 1 << LV;

    for (genvar l = 0; l <= LV; l++) begin : lvl
        localparam int N = P >> l;
        logic [OW-1:0] s [N];
        for (genvar i = 0; i < N; i++) begin : nd
            if (l == 0) begin : leaf
                if (i < W) begin : used
                    assign s[i] = OW'(din[i]);
                end else begin : pad
                    assign s[i] = '0;
                end
            end else begin : add
                assign s[i] = lvl[l-1].s[2*i] + lvl[l-1].s[2*i+1];
            end
        end
    end

    assign cnt = lvl[LV].s[0];
endmodule

// File: rtl/hv_assoc_search.sv
// Loads a bit-serial query, streams every class row from RAM and keeps the
// class with the highest overlap (lowest index wins ties).
module hv_assoc_search
    import hdc_pkg::*;
(
    input  logic              clk,
    input  logic              nrst,
    hv_assoc_search_if.slave  bus
);
    state_t state, state_nx;

    logic [HV_DIM-1:0]   query;
    logic [BIT_W-1:0]    bit_cnt, wr_idx;
    logic [CHUNK_IW-1:0] chunk_cnt, d_chunk;
    logic [CLASS_W-1:0]  cls_cnt, d_cls, best_class;
    logic [SCORE_W-1:0]  acc, sum, best_score;
    logic [PC_W-1:0]     pc;
    logic                d_vld, accept, last_bit, last_addr;

    assign bus.query_ready = (state == IDLE) || (state == LOAD);
    assign accept    = bus.query_valid && bus.query_ready;
    assign wr_idx    = (state == IDLE) ? '0 : bit_cnt;
    assign last_bit  = (state == LOAD) && accept && (bit_cnt == BIT_W'(HV_DIM - 1));
    assign last_addr = (chunk_cnt == CHUNK_IW'(NCHUNK - 1)) && (cls_cnt == CLASS_W'(CLASS_COUNT - 1));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = LOAD;
            LOAD:    if (last_bit) state_nx = SEARCH;
            SEARCH:  if (last_addr) state_nx = DRAIN;
            DRAIN:   state_nx = DONE;
            DONE:    if (bus.result_valid && bus.result_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Data for the chunk issued last cycle arrives now; tags ride alongside.
    popcount_chunk #(.W(CHUNK_W), .OW(PC_W)) u_pc (
        .din (query[d_chunk*CHUNK_W +: CHUNK_W] & bus.mem_rd_data),
        .cnt (pc)
    );
    assign sum = ((d_chunk == '0) ? '0 : acc) + SCORE_W'(pc);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            query            <= '0;
            bit_cnt          <= '0;
            chunk_cnt        <= '0;
            cls_cnt          <= '0;
            d_vld            <= 1'b0;
            d_chunk          <= '0;
            d_cls            <= '0;
            acc              <= '0;
            best_score       <= '0;
            best_class       <= '0;
            bus.mem_rd_en    <= 1'b0;
            bus.mem_rd_addr  <= '0;
            bus.result_valid <= 1'b0;
            bus.result_class <= '0;
            bus.result_score <= '0;
        end else begin
            if (accept) begin
                query[wr_idx] <= bus.query_bit;
                bit_cnt       <= wr_idx + BIT_W'(1);
            end

            if (last_bit) begin
                bus.mem_rd_en   <= 1'b1;
                bus.mem_rd_addr <= '0;
                chunk_cnt       <= '0;
                cls_cnt         <= '0;
            end else if (state == SEARCH) begin
                if (last_addr) begin
                    bus.mem_rd_en <= 1'b0;
                end else begin
                    bus.mem_rd_addr <= bus.mem_rd_addr + ADDR_W'(1);
                    if (chunk_cnt == CHUNK_IW'(NCHUNK - 1)) begin
                        chunk_cnt <= '0;
                        cls_cnt   <= cls_cnt + CLASS_W'(1);
                    end else begin
                        chunk_cnt <= chunk_cnt + CHUNK_IW'(1);
                    end
                end
            end

            d_vld   <= bus.mem_rd_en;
            d_chunk <= chunk_cnt;
            d_cls   <= cls_cnt;

            if (d_vld) begin
                acc <= sum;
                // Strict compare keeps the earlier class on ties.
                if (d_chunk == CHUNK_IW'(NCHUNK - 1) && (sum > best_score || d_cls == '0)) begin
                    best_score <= sum;
                    best_class <= d_cls;
                end
            end

            if (state == DONE && !bus.result_valid) begin
                bus.result_valid <= 1'b1;
                bus.result_class <= best_class;
                bus.result_score <= best_score;
            end else if (bus.result_valid && bus.result_ready) begin
                bus.result_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_hv_assoc_search.sv
// Directed bench for hv_assoc_search: behavioural class RAM, reference argmax
// model feeding a result scoreboard, address-stream monitor.
module tb_hv_assoc_search;
    import hdc_pkg::*;

    typedef struct packed {
        logic [CLASS_W-1:0] c;
        logic [SCORE_W-1:0] s;
    } res_t;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    hv_assoc_search_if bus();
    hv_assoc_search dut (.clk(clk), .nrst(nrst), .bus(bus));

    logic [CHUNK_W-1:0] ram [CLASS_COUNT*NCHUNK];
    logic [HV_DIM-1:0]  cls_hv [CLASS_COUNT];
    logic [HV_DIM-1:0]  q1, qz, qo;
    int                 ones_idx [40];
    res_t               sb [$];

    int n_chk = 0, n_pass = 0;
    int en_cnt = 0, addr_err = 0;
    logic [ADDR_W:0] exp_addr = '0;

    always @(posedge clk)
        if (bus.mem_rd_en) bus.mem_rd_data <= ram[bus.mem_rd_addr];

    always @(negedge clk) begin
        if (!nrst) begin
            en_cnt = 0; addr_err = 0; exp_addr = '0;
        end else if (bus.mem_rd_en) begin
            if ({1'b0, bus.mem_rd_addr} !== exp_addr) addr_err++;
            exp_addr++;
            en_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic logic [HV_DIM-1:0] rnd_hv();
        logic [HV_DIM-1:0] r;
        for (int w = 0; w < HV_DIM/32; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic res_t model(input logic [HV_DIM-1:0] q);
        res_t b;
        int   sc;
        b = '0;
        for (int c = 0; c < CLASS_COUNT; c++) begin
            sc = $countones(q & cls_hv[c]);
            if (c == 0 || sc > int'(b.s)) begin
                b.c = CLASS_W'(c);
                b.s = SCORE_W'(sc);
            end
        end
        return b;
    endfunction

    task automatic load_ram();
        for (int c = 0; c < CLASS_COUNT; c++)
            for (int k = 0; k < NCHUNK; k++)
                ram[c*NCHUNK + k] = cls_hv[c][k*CHUNK_W +: CHUNK_W];
    endtask

    task automatic build_match();
        for (int c = 0; c < CLASS_COUNT; c++) begin
            cls_hv[c] = rnd_hv() & ~q1;
            for (int j = 0; j < 40; j++) if (j % 3 == c % 3) cls_hv[c][ones_idx[j]] = 1'b1;
        end
        cls_hv[5] = q1;
        load_ram();
    endtask

    task automatic build_tie();
        for (int c = 0; c < CLASS_COUNT; c++) begin
            cls_hv[c] = rnd_hv() & ~q1;
            for (int j = 0; j < 40; j++)
                if ((c == 3 || c == 7) ? (j < 12) : (j % 5 == c % 5)) cls_hv[c][ones_idx[j]] = 1'b1;
        end
        load_ram();
    endtask

    task automatic send_bits(input logic [HV_DIM-1:0] q, input bit gappy);
        bit acc;
        int guard;
        en_cnt = 0; addr_err = 0; exp_addr = '0;
        sb.push_back(model(q));
        guard = 0;
        for (int i = 0; i < HV_DIM; i++) begin
            acc = 1'b0;
            while (!acc) begin
                @(negedge clk);
                bus.query_valid = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.query_bit   = q[i];
                acc = bus.query_valid && bus.query_ready;
                guard++;
                if (guard > 20000) begin
                    $display("FAIL load_timeout: query_ready stuck low at bit %0d", i);
                    $fatal(1, "load timeout");
                end
            end
        end
        @(negedge clk);
        bus.query_valid = 1'b0;
    endtask

    // Cycles from the edge accepting the last bit to result_valid.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!bus.result_valid && lat < 1000) begin
            if (lat == 5) chk("busy_qready", 32'(bus.query_ready), 0);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take_result(input int hold);
        res_t e, h;
        bit   stable;
        if (hold > 0) begin
            h = {bus.result_class, bus.result_score};
            stable = 1'b1;
            bus.result_ready = 1'b0;
            repeat (hold) begin
                @(negedge clk);
                if (!bus.result_valid || bus.query_ready || {bus.result_class, bus.result_score} !== h)
                    stable = 1'b0;
            end
            chk("hold_stable", 32'(stable), 1);
            chk("hold_qready", 32'(bus.query_ready), 0);
        end
        if (sb.size() == 0) begin
            chk("sb_empty", 32'(sb.size()), 1);
            e = '0;
        end else begin
            e = sb.pop_front();
        end
        chk("res_valid", 32'(bus.result_valid), 1);
        chk("res_class", 32'(bus.result_class), 32'(e.c));
        chk("res_score", 32'(bus.result_score), 32'(e.s));
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
        chk("post_valid", 32'(bus.result_valid), 0);
        chk("post_qready", 32'(bus.query_ready), 1);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_rd_en"},  32'(bus.mem_rd_en), 0);
        chk({tag, "_addr"},   32'(bus.mem_rd_addr), 0);
        chk({tag, "_valid"},  32'(bus.result_valid), 0);
        chk({tag, "_class"},  32'(bus.result_class), 0);
        chk({tag, "_score"},  32'(bus.result_score), 0);
        chk({tag, "_qready"}, 32'(bus.query_ready), 1);
    endtask

    initial begin
        int lat, guard;
        bus.query_valid = 1'b0; bus.query_bit = 1'b0; bus.result_ready = 1'b0;
        q1 = '0; qz = '0; qo = '1;
        for (int j = 0; j < 40; j++) begin
            ones_idx[j] = j*25 + 3;
            q1[j*25 + 3] = 1'b1;
        end
        repeat (3) @(negedge clk);
        chk_reset_outs("rst");
        nrst = 1'b1;
        @(negedge clk);

        // Exact match in class 5, with latency and address-stream checks
        build_match();
        send_bits(q1, 1'b0);
        wait_result(lat);
        chk("match_latency", 32'(lat), 418);
        chk("match_en_cycles", 32'(en_cnt), 416);
        chk("match_addr_err", 32'(addr_err), 0);
        chk("match_class", 32'(bus.result_class), 5);
        chk("match_score", 32'(bus.result_score), 40);
        take_result(0);

        // Tie between classes 3 and 7
        build_tie();
        send_bits(q1, 1'b0);
        wait_result(lat);
        chk("tie_class", 32'(bus.result_class), 3);
        chk("tie_score", 32'(bus.result_score), 12);
        take_result(0);

        // All-zero query
        send_bits(qz, 1'b0);
        wait_result(lat);
        chk("zero_class", 32'(bus.result_class), 0);
        chk("zero_score", 32'(bus.result_score), 0);
        take_result(0);

        // All-ones query, class 25 all ones, others half ones
        for (int c = 0; c < CLASS_COUNT; c++)
            for (int i = 0; i < HV_DIM; i++) cls_hv[c][i] = (c == CLASS_COUNT-1) ? 1'b1 : 1'(i % 2);
        load_ram();
        send_bits(qo, 1'b0);
        wait_result(lat);
        chk("ones_class", 32'(bus.result_class), 25);
        chk("ones_score", 32'(bus.result_score), 1024);
        take_result(0);

        // Gappy load, delayed result_ready, then back-to-back second query
        build_match();
        send_bits(q1, 1'b1);
        wait_result(lat);
        chk("gap_latency", 32'(lat), 418);
        take_result(10);
        build_tie();
        send_bits(q1, 1'b0);
        wait_result(lat);
        chk("b2b_class", 32'(bus.result_class), 3);
        chk("b2b_addr_err", 32'(addr_err), 0);
        take_result(0);

        // Reset in the middle of the search
        send_bits(q1, 1'b0);
        guard = 0;
        while (bus.mem_rd_addr != ADDR_W'(200) && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        chk("mid_reached_200", 32'(bus.mem_rd_addr), 200);
        nrst = 1'b0;
        #1;
        chk_reset_outs("midrst");
        void'(sb.pop_front());
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        build_match();
        send_bits(q1, 1'b0);
        wait_result(lat);
        chk("after_rst_latency", 32'(lat), 418);
        chk("after_rst_class", 32'(bus.result_class), 5);
        chk("after_rst_score", 32'(bus.result_score), 40);
        chk("after_rst_en", 32'(en_cnt), 416);
        take_result(0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
